// File: rtl/sub32_seq.sv
// Multi-cycle 32-bit subtractor d = a - b - bi, DIGIT_W bits per cycle, LSB digit first.
// Define SUB32_SEQ_OVF_EN to add the signed-overflow output ovf.
module sub32_seq #(
  parameter int DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bi,
  output logic        busy,
  output logic        done,
  output logic [31:0] d,
  output logic        bo
`ifdef SUB32_SEQ_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int N     = 32 / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic               load, step, last;
  logic [31:0]        a_reg, b_reg, res_reg, d_reg;
  logic [31:0]        a_next, b_next, res_next;
  logic               borrow_reg, bo_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DIGIT_W-1:0] a_dig, b_dig, diff_dig;
  logic               borrow_dig;

  // Operand registers shift right so the active digit is always at the bottom.
  assign a_dig = a_reg[DIGIT_W-1:0];
  assign b_dig = b_reg[DIGIT_W-1:0];
  assign {borrow_dig, diff_dig} = {1'b0, a_dig} - {1'b0, b_dig}
                                  - {{DIGIT_W{1'b0}}, borrow_reg};
  assign last = (cnt_reg == CNT_W'(N - 1));

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dig
      if (gi == N - 1) begin : g_top
        assign a_next[gi*DIGIT_W +: DIGIT_W] = '0;
        assign b_next[gi*DIGIT_W +: DIGIT_W] = '0;
      end else begin : g_mid
        assign a_next[gi*DIGIT_W +: DIGIT_W] = a_reg[(gi+1)*DIGIT_W +: DIGIT_W];
        assign b_next[gi*DIGIT_W +: DIGIT_W] = b_reg[(gi+1)*DIGIT_W +: DIGIT_W];
      end
      // Result digits land in their final slot, selected by the counter.
      assign res_next[gi*DIGIT_W +: DIGIT_W] = (cnt_reg == CNT_W'(gi)) ? diff_dig
                                               : res_reg[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      d_reg      <= '0;
      bo_reg     <= 1'b0;
    end else if (load) begin
      a_reg      <= a;
      b_reg      <= b;
      borrow_reg <= bi;
      cnt_reg    <= '0;
    end else if (step) begin
      a_reg      <= a_next;
      b_reg      <= b_next;
      res_reg    <= res_next;
      borrow_reg <= borrow_dig;
      cnt_reg    <= cnt_reg + CNT_W'(1);
      if (last) begin
        d_reg  <= res_next;
        bo_reg <= borrow_dig;
      end
    end
  end

`ifdef SUB32_SEQ_OVF_EN
  // Sign bits are kept apart because the operand registers are shifted away.
  logic a_msb_reg, b_msb_reg, ovf_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (load) begin
      a_msb_reg <= a[31];
      b_msb_reg <= b[31];
    end else if (step && last) begin
      ovf_reg <= (a_msb_reg != b_msb_reg) && (res_next[31] != a_msb_reg);
    end
  end

  assign ovf = ovf_reg;
`endif

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign d    = d_reg;
  assign bo   = bo_reg;

endmodule

// File: tb/tb_sub32_seq.sv
// Self-checking bench for sub32_seq: vector table through a scoreboard, handshake
// corner cases, mid-run reset and a DIGIT_W sweep.
module tb_sub32_seq;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    exp_t        e;
  } vec_t;

  localparam int SW [3] = '{1, 8, 32};

  logic        clk = 1'b0;
  logic        rstn, start, bi;
  logic [31:0] a, b;
  logic        busy, done, bo;
  logic [31:0] d;
  logic [2:0]  start_w, busy_w, done_w, bo_w;
  logic [31:0] d_w [3];
`ifdef SUB32_SEQ_OVF_EN
  logic        ovf;
  logic [2:0]  ovf_w;
`endif

  int   n_run  = 0;
  int   n_fail = 0;
  exp_t sb [$];
  vec_t vec [8];

  always #5 clk = ~clk;

  sub32_seq #(.DIGIT_W(4)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .a(a), .b(b), .bi(bi),
    .busy(busy), .done(done), .d(d), .bo(bo)
`ifdef SUB32_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    sub32_seq #(.DIGIT_W(SW[gi])) u_sw (
      .clk(clk), .rstn(rstn), .start(start_w[gi]), .a(a), .b(b), .bi(bi),
      .busy(busy_w[gi]), .done(done_w[gi]), .d(d_w[gi]), .bo(bo_w[gi])
`ifdef SUB32_SEQ_OVF_EN
      , .ovf(ovf_w[gi])
`endif
    );
  end

  function automatic vec_t mkv(input logic [31:0] va, input logic [31:0] vb, input logic vbi,
                               input logic [31:0] vd, input logic vbo, input logic vovf);
    vec_t v;
    v.a = va; v.b = vb; v.bi = vbi;
    v.e.d = vd; v.e.bo = vbo; v.e.ovf = vovf;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one start pulse; leaves the bench in RUN cycle 1.
  task automatic start_op(input vec_t v);
    a = v.a; b = v.b; bi = v.bi;
    start = 1'b1;
    sb.push_back(v.e);
    tick;
    start = 1'b0;
    a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
  endtask

  // Wait for done from cycle cyc0, then check latency, busy shape and the scoreboard head.
  task automatic finish_op(input string name, input int exp_lat, input int cyc0);
    int   cyc;
    logic ok;
    exp_t e;
    cyc = cyc0;
    ok  = 1'b1;
    while (!done && cyc < 64) begin
      if (busy !== 1'b1) ok = 1'b0;
      tick;
      cyc++;
    end
    if (busy !== 1'b0) ok = 1'b0;
    chk({name, " latency"}, cyc, exp_lat);
    chk({name, " busy"}, {31'd0, ok}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (done) begin
        chk({name, " d"}, d, e.d);
        chk({name, " bo"}, {31'd0, bo}, {31'd0, e.bo});
`ifdef SUB32_SEQ_OVF_EN
        chk({name, " ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
`endif
      end
    end
  endtask

  initial begin
    int   cyc;
    logic seen;

    vec[0] = mkv(32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    vec[1] = mkv(32'h12345678, 32'h87654321, 1'b0, 32'h8ACF1357, 1'b1, 1'b1);
    vec[2] = mkv(32'h0000BCDA, 32'h0000ABCD, 1'b0, 32'h0000110D, 1'b0, 1'b0);
    vec[3] = mkv(32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    vec[4] = mkv(32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    vec[5] = mkv(32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0);
    vec[6] = mkv(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);
    vec[7] = mkv(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);

    rstn = 1'b0; start = 1'b0; start_w = '0;
    a = '0; b = '0; bi = 1'b0;
    repeat (3) tick;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset d", d, 32'd0);
    chk("reset bo", {31'd0, bo}, 32'd0);
    rstn = 1'b1;
    tick;

    for (int i = 0; i < 8; i++) begin
      start_op(vec[i]);
      if (i > 0) chk($sformatf("vec%0d hold d", i), d, vec[i-1].e.d);
      finish_op($sformatf("vec%0d", i), 9, 1);
      tick;
    end

    // start pulsed in RUN cycle 3 must be ignored
    start_op(vec[1]);
    tick; tick;
    a = vec[2].a; b = vec[2].b; bi = vec[2].bi; start = 1'b1;
    tick;
    start = 1'b0;
    finish_op("ignore start", 9, 4);
    tick;

    // start held through DONE: back-to-back, second done 9 cycles after the first
    a = vec[3].a; b = vec[3].b; bi = vec[3].bi; start = 1'b1;
    sb.push_back(vec[3].e);
    tick;
    a = vec[6].a; b = vec[6].b; bi = vec[6].bi;
    finish_op("b2b first", 9, 1);
    sb.push_back(vec[6].e);
    tick;
    start = 1'b0;
    finish_op("b2b second", 9, 1);
    tick;

    // reset in RUN cycle 4 discards the operation
    start_op(vec[5]);
    tick; tick; tick;
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst d", d, 32'd0);
    chk("midrst bo", {31'd0, bo}, 32'd0);
    sb.delete();
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (done) seen = 1'b1;
    end
    chk("midrst no done", {31'd0, seen}, 32'd0);

    start_op(vec[2]);
    finish_op("after reset", 9, 1);
    tick;

    for (int k = 0; k < 3; k++) begin
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; bi = 1'b1;
      start_w[k] = 1'b1;
      tick;
      start_w[k] = 1'b0;
      a = $urandom; b = $urandom;
      cyc = 1;
      while (!done_w[k] && cyc < 64) begin
        tick;
        cyc++;
      end
      chk($sformatf("sweep w%0d latency", SW[k]), cyc, 32 / SW[k] + 1);
      chk($sformatf("sweep w%0d d", SW[k]), d_w[k], 32'hFFFFFFFF);
      chk($sformatf("sweep w%0d bo", SW[k]), {31'd0, bo_w[k]}, 32'd1);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
